// File: rtl/text_tile_renderer.sv
// Text-mode pixel generator: character buffer with colour/blink attributes, scaled glyphs,
// blinking cursor, boot/clr buffer sweep and a three-stage pix_tick-qualified pixel pipeline.

module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  function automatic logic [7:0] glyph(input logic [6:0] ch, input logic [3:0] row);
    logic [7:0] g;
    g = 8'h00;
    case (ch)
      7'h20: g = 8'h00;
      7'h7f: g = 8'hff;
      7'h41: begin
        case (row)
          4'd1:                     g = 8'h18;
          4'd2:                     g = 8'h3c;
          4'd3:                     g = 8'h66;
          4'd4, 4'd5:               g = 8'hc3;
          4'd6:                     g = 8'hff;
          4'd7, 4'd8, 4'd9, 4'd10:  g = 8'hc3;
          default:                  g = 8'h00;
        endcase
      end
      default: g = {ch[3:0], row};
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    data <= glyph(addr[10:4], addr[3:0]);
  end
endmodule

module text_tile_renderer #(
  parameter int         SCALE_LOG2   = 1,
  parameter int         COLS         = 640 >> (3 + SCALE_LOG2),
  parameter int         ROWS         = 480 >> (4 + SCALE_LOG2),
  parameter logic [2:0] FG_DEFAULT   = 3'b010,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [2:0]  bg_color,
  input  logic        wr_en,
  input  logic [6:0]  wr_col,
  input  logic [5:0]  wr_row,
  input  logic [10:0] wr_data,
  input  logic        clr,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic        busy,
  output logic [2:0]  rgb_text,
  output logic        hsync_out,
  output logic        vsync_out
);
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [10:0]   CLEAR_WORD = {1'b0, FG_DEFAULT, 7'h20};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   clr_addr;
  logic [10:0]     mem [DEPTH];

  // Clear sweep: one cell per clk, independent of pix_tick; clr is ignored mid-sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic          wr_ok;
  logic [AW-1:0] wr_addr;
  assign wr_ok   = wr_en && !busy && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
  assign wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= CLEAR_WORD;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic [9:0] col_full, row_full;
  logic [3:0] grow_c;
  logic [2:0] gcol_c;
  logic       in_range_c, cursor_c;
  assign col_full   = pixel_x >> (3 + SCALE_LOG2);
  assign row_full   = pixel_y >> (4 + SCALE_LOG2);
  assign grow_c     = 4'(pixel_y >> SCALE_LOG2);
  assign gcol_c     = 3'(pixel_x >> SCALE_LOG2);
  assign in_range_c = (int'(col_full) < COLS) && (int'(row_full) < ROWS);
  assign cursor_c   = cursor_en && (col_full == {3'b000, cursor_col}) &&
                      (row_full == {4'b0000, cursor_row}) && (grow_c[3:1] == 3'b111);

  logic       a_video, a_hs, a_vs, a_in, a_cur;
  logic [6:0] a_col;
  logic [5:0] a_row;
  logic [3:0] a_grow;
  logic [2:0] a_gcol;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_video <= 1'b0;
      a_hs    <= 1'b0;
      a_vs    <= 1'b0;
      a_in    <= 1'b0;
      a_cur   <= 1'b0;
      a_col   <= '0;
      a_row   <= '0;
      a_grow  <= '0;
      a_gcol  <= '0;
    end else if (pix_tick) begin
      a_video <= video_on;
      a_hs    <= hsync_in;
      a_vs    <= vsync_in;
      a_in    <= in_range_c;
      a_cur   <= cursor_c;
      a_col   <= col_full[6:0];
      a_row   <= row_full[5:0];
      a_grow  <= grow_c;
      a_gcol  <= gcol_c;
    end
  end

  // Combinational read sees the pre-write contents, giving read-first behaviour.
  logic [AW-1:0] rd_addr;
  logic [10:0]   rd_data;
  assign rd_addr = a_in ? AW'(int'(a_row) * COLS + int'(a_col)) : '0;
  assign rd_data = mem[rd_addr];

  logic        b_video, b_hs, b_vs, b_in, b_cur;
  logic [10:0] b_cell;
  logic [3:0]  b_grow;
  logic [2:0]  b_gcol;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_video <= 1'b0;
      b_hs    <= 1'b0;
      b_vs    <= 1'b0;
      b_in    <= 1'b0;
      b_cur   <= 1'b0;
      b_cell  <= '0;
      b_grow  <= '0;
      b_gcol  <= '0;
    end else if (pix_tick) begin
      b_video <= a_video;
      b_hs    <= a_hs;
      b_vs    <= a_vs;
      b_in    <= a_in;
      b_cur   <= a_cur;
      b_cell  <= rd_data;
      b_grow  <= a_grow;
      b_gcol  <= a_gcol;
    end
  end

  // The ROM address tracks what stage B is loading on a tick and stage B's held value
  // otherwise, so font_word is ready for stage C even with pix_tick tied high.
  logic [10:0] font_addr;
  logic [7:0]  font_word;
  assign font_addr = pix_tick ? {rd_data[6:0], a_grow} : {b_cell[6:0], b_grow};

  font_rom u_font_rom (
    .clk  (clk),
    .addr (font_addr),
    .data (font_word)
  );

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (pix_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0)) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_text  <= 3'b000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (pix_tick) begin
      hsync_out <= b_hs;
      vsync_out <= b_vs;
      if (!b_video) begin
        rgb_text <= 3'b000;
      end else if (!b_in) begin
        rgb_text <= bg_color;
      end else if (b_cell[10] && blink_phase) begin
        rgb_text <= bg_color;
      end else if (b_cur && !blink_phase) begin
        rgb_text <= b_cell[9:7];
      end else if (font_word[3'd7 - b_gcol]) begin
        rgb_text <= b_cell[9:7];
      end else begin
        rgb_text <= bg_color;
      end
    end
  end
endmodule

// File: tb/tb_text_tile_renderer.sv
// Directed bench for text_tile_renderer at SCALE_LOG2=1 (20x15 cells) with a 2-frame blink.

module tb_text_tile_renderer;
  localparam int         S    = 1;
  localparam int         COLS = 20;
  localparam int         ROWS = 15;
  localparam int         BF   = 2;
  localparam logic [2:0] FGD  = 3'b010;
  localparam logic [2:0] BG   = 3'b001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_tick, video_on, hsync_in, vsync_in;
  logic [9:0]  pixel_x, pixel_y;
  logic [2:0]  bg_color;
  logic        wr_en;
  logic [6:0]  wr_col;
  logic [5:0]  wr_row;
  logic [10:0] wr_data;
  logic        clr, cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;
  logic [2:0]  rgb_text;
  logic        hsync_out, vsync_out;

  always #5 clk = ~clk;

  text_tile_renderer #(
    .SCALE_LOG2(S), .COLS(COLS), .ROWS(ROWS), .FG_DEFAULT(FGD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_tick(pix_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .bg_color(bg_color), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
    .wr_data(wr_data), .clr(clr), .cursor_en(cursor_en), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .busy(busy), .rgb_text(rgb_text),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic [2:0] exp_rgb;
    logic       exp_hs;
    logic       exp_vs;
  } vec_t;

  vec_t       vecs[64];
  int         n_vec;
  logic [4:0] exp_q[$];
  logic [7:0] glyph_a[16];
  int         checks = 0;
  int         errors = 0;
  int         exp_cnt = 0;
  logic       exp_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    pixel_x  = 10'd700;
    pixel_y  = 10'd500;
    video_on = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    pix_tick = 1'b1;
  endtask

  task automatic add_vec(input int x, input int y, input logic von, input logic hs,
                         input logic vs, input logic [2:0] rgb);
    vecs[n_vec].x       = 10'(x);
    vecs[n_vec].y       = 10'(y);
    vecs[n_vec].von     = von;
    vecs[n_vec].hs      = hs;
    vecs[n_vec].vs      = vs;
    vecs[n_vec].exp_rgb = rgb;
    vecs[n_vec].exp_hs  = hs;
    vecs[n_vec].exp_vs  = vs;
    n_vec++;
  endtask

  function automatic logic [2:0] a_pix(input int x, input int grow, input logic [2:0] fg);
    logic [7:0] g;
    g = glyph_a[grow];
    return g[7 - ((x >> 1) & 7)] ? fg : BG;
  endfunction

  // Streams vecs through the pipeline, one per tick; non-tick cycles carry junk inputs.
  task automatic run_stream(input string name, input int period);
    int         idx = 0;
    int         popped = 0;
    int         cyc = 0;
    logic       have = 1'b0;
    logic       ticked;
    logic [4:0] cur = '0;
    exp_q.delete();
    while (popped < n_vec && cyc < 2000) begin
      ticked = (cyc % period) == 0;
      pix_tick = ticked;
      if (ticked && idx < n_vec) begin
        pixel_x  = vecs[idx].x;
        pixel_y  = vecs[idx].y;
        video_on = vecs[idx].von;
        hsync_in = vecs[idx].hs;
        vsync_in = vecs[idx].vs;
      end else if (ticked) begin
        go_idle();
      end else begin
        pixel_x  = 10'($urandom_range(1, 639));
        pixel_y  = 10'($urandom_range(1, 479));
        video_on = 1'($urandom_range(0, 1));
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (ticked) begin
        if (idx < n_vec) exp_q.push_back({vecs[idx].exp_rgb, vecs[idx].exp_hs, vecs[idx].exp_vs});
        else             exp_q.push_back(5'b0);
        idx++;
        if (exp_q.size() == 3) begin
          cur = exp_q.pop_front();
          have = 1'b1;
          popped++;
        end
      end
      if (have) check(name, {rgb_text, hsync_out, vsync_out}, cur);
      cyc++;
    end
    if (popped < n_vec) check({name, "_timeout"}, popped, n_vec);
    go_idle();
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [2:0] exp);
    pix_tick = 1'b1;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(name, rgb_text, exp);
    go_idle();
  endtask

  task automatic frame_start();
    pix_tick = 1'b1;
    pixel_x  = 10'd0;
    pixel_y  = 10'd0;
    video_on = 1'b1;
    @(posedge clk); #1;
    if (exp_cnt == BF - 1) begin
      exp_cnt   = 0;
      exp_phase = ~exp_phase;
    end else begin
      exp_cnt++;
    end
    go_idle();
  endtask

  task automatic write_cell(input int col, input int row, input logic [10:0] data);
    wr_en   = 1'b1;
    wr_col  = 7'(col);
    wr_row  = 6'(row);
    wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    int cnt;
    glyph_a[0]  = 8'h00; glyph_a[1]  = 8'h18; glyph_a[2]  = 8'h3c; glyph_a[3]  = 8'h66;
    glyph_a[4]  = 8'hc3; glyph_a[5]  = 8'hc3; glyph_a[6]  = 8'hff; glyph_a[7]  = 8'hc3;
    glyph_a[8]  = 8'hc3; glyph_a[9]  = 8'hc3; glyph_a[10] = 8'hc3; glyph_a[11] = 8'h00;
    glyph_a[12] = 8'h00; glyph_a[13] = 8'h00; glyph_a[14] = 8'h00; glyph_a[15] = 8'h00;

    // Clock/reset
    reset_n = 1'b0;
    go_idle();
    bg_color = BG;
    wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0;
    clr = 1'b0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", rgb_text, 3'b000);
    check("reset_sync", {hsync_out, vsync_out}, 2'b00);
    check("reset_busy", busy, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("boot_busy_len", cnt, 300);

    // Cleared buffer: every visible pixel is background
    n_vec = 0;
    add_vec(5, 7, 1, 1, 0, BG);
    add_vec(100, 50, 1, 0, 1, BG);
    add_vec(319, 239, 1, 1, 1, BG);
    add_vec(200, 100, 1, 0, 0, BG);
    add_vec(320, 5, 1, 1, 0, BG);
    add_vec(639, 479, 1, 0, 1, BG);
    add_vec(100, 50, 0, 1, 1, 3'b000);
    add_vec(48, 93, 1, 0, 0, BG);
    run_stream("cleared", 1);

    // 'A' at (0,0); wr_col=20 would alias to (0,1) if not dropped
    write_cell(0, 0, {1'b0, 3'b100, 7'h41});
    write_cell(20, 0, {1'b0, 3'b111, 7'h7f});
    n_vec = 0;
    for (int x = 0; x < 16; x++) add_vec(x, 2, 1, x[0], x[2], a_pix(x, 1, 3'b100));
    for (int x = 0; x < 16; x++) add_vec(x, 3, 1, x[1], x[0], a_pix(x, 1, 3'b100));
    add_vec(12, 12, 1, 1, 0, a_pix(12, 6, 3'b100));
    add_vec(16, 2, 1, 0, 1, BG);
    add_vec(17, 3, 1, 1, 1, BG);
    add_vec(4, 40, 1, 0, 0, BG);
    add_vec(7, 2, 0, 1, 0, 3'b000);
    run_stream("glyph_a", 1);

    // clr sweep: re-clr mid-sweep ignored, writes during sweep dropped
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_busy_rise", busy, 1'b1);
    cnt = 0;
    while (busy && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      clr   = (cnt == 5);
      wr_en = (cnt == 10);
      wr_col = 7'd1; wr_row = 6'd0; wr_data = {1'b0, 3'b111, 7'h7f};
    end
    clr = 1'b0; wr_en = 1'b0;
    check("clr_busy_len", cnt, 300);
    probe("clr_wipes_a", 6, 2, BG);
    probe("busy_write_dropped", 20, 4, BG);

    // Blink cell (2,0), solid glyph
    write_cell(2, 0, {1'b1, 3'b111, 7'h7f});
    probe("blink_f0", 40, 4, exp_phase ? BG : 3'b111);
    for (int f = 1; f <= 4; f++) begin
      frame_start();
      probe($sformatf("blink_f%0d", f), 40, 4, exp_phase ? BG : 3'b111);
    end

    // Cursor at (3,2) over a space
    cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 6'd2;
    probe("cursor_tl", 48, 92, exp_phase ? BG : FGD);
    probe("cursor_br", 63, 95, exp_phase ? BG : FGD);
    probe("cursor_row13", 48, 91, BG);
    probe("cursor_col4", 64, 92, BG);
    frame_start();
    frame_start();
    probe("cursor_ph_tl", 48, 92, exp_phase ? BG : FGD);
    probe("cursor_ph_br", 60, 94, exp_phase ? BG : FGD);
    frame_start();
    frame_start();
    probe("cursor_back", 55, 93, exp_phase ? BG : FGD);
    cursor_en = 1'b0;

    // 1-in-4 pix_tick
    write_cell(0, 0, {1'b0, 3'b100, 7'h41});
    n_vec = 0;
    for (int x = 0; x < 16; x++) add_vec(x, 6, 1, x[0], x[1], a_pix(x, 3, 3'b100));
    add_vec(16, 6, 1, 1, 0, BG);
    add_vec(3, 12, 1, 0, 1, a_pix(3, 6, 3'b100));
    add_vec(5, 6, 0, 1, 1, 3'b000);
    run_stream("tick4", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_tile_renderer.md
# text_tile_renderer

Parametrised text-mode pixel generator for the VGA controller. It sits between the sync/pixel-counter block and the RGB output pins. It holds a writable character buffer with per-cell colour and blink attributes, reads glyphs from the existing `font_rom`, and supports integer glyph scaling, a blinking cursor and a boot-time buffer clear. Sync signals are delayed alongside the pixel data so they stay aligned with `rgb_text`.

## Interface
- `SCALE_LOG2`, 1: glyph magnification 2^S, with S restricted to 0..2. Cell size is (8<<S) x (16<<S) pixels.
- `COLS`, 640>>(3+SCALE_LOG2): number of text columns.
- `ROWS`, 480>>(4+SCALE_LOG2): number of text rows.
- `FG_DEFAULT`, 3'b010: foreground colour written by the clear sweep.
- `BLINK_FRAMES`, 30: number of frames per blink half-period.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pix_tick`  in  1  pixel enable. All pipeline registers and the blink counter advance only when this is 1.
- `video_on`  in  1  visible-area flag from the sync block.
- `hsync_in`, `vsync_in`  in  1 each  raw sync signals.
- `pixel_x`, `pixel_y`  in  10 each  current pixel coordinates.
- `bg_color`  in  3  background colour.
- `wr_en`  in  1  character buffer write strobe. Not gated by `pix_tick`.
- `wr_col`  in  7  target column of the write.
- `wr_row`  in  6  target row of the write.
- `wr_data`  in  11  cell contents, {blink, fg[2:0], char[6:0]}.
- `clr`  in  1  one-cycle pulse that starts a buffer clear.
- `cursor_en`  in  1  cursor enable.
- `cursor_col`  in  7  cursor column.
- `cursor_row`  in  6  cursor row.
- `busy`  out  1  high while a clear sweep is running.
- `rgb_text`  out  3  pixel colour.
- `hsync_out`, `vsync_out`  out  1 each  sync signals delayed to align with `rgb_text`.

## Operation
- Character buffer:
  - COLS*ROWS entries of 11 bits, dual-port.
  - Write address is wr_row*COLS+wr_col. A write happens when `wr_en` is 1, `busy` is 0, and the coordinates are in range. Any other write is silently dropped.
  - Read behaviour is read-first: a read and a write to the same cell in the same cycle returns the old data.
- Clear FSM:
  - States are IDLE and CLEAR.
  - Reset enters CLEAR with the address at 0.
  - CLEAR writes {1'b0, FG_DEFAULT, 7'h20} to one cell per clk, regardless of `pix_tick`. After the last address (COLS*ROWS-1) it returns to IDLE.
  - `clr` in IDLE moves the FSM to CLEAR with the address at 0. `clr` during CLEAR is ignored; the sweep does not restart.
  - `busy` is 1 in CLEAR and 0 in IDLE.
- Coordinate mapping:
  - col = pixel_x>>(3+S), row = pixel_y>>(4+S).
  - glyph_row = (pixel_y>>S)[3:0], glyph_col = (pixel_x>>S)[2:0].
  - The pixel is in range when col<COLS and row<ROWS.
- Glyph fetch:
  - `font_rom` address is {char, glyph_row}.
  - The glyph pixel is font_word[7-glyph_col], so bit 7 is the leftmost pixel.
- Blink:
  - A frame start is a `pix_tick` with pixel_x==0 and pixel_y==0.
  - frame_cnt counts frame starts from 0 to BLINK_FRAMES-1. On wrap it returns to 0 and toggles blink_phase.
- Pixel colour, evaluated in priority order:
  - `video_on` is 0 → 000.
  - Pixel is not in range → `bg_color`.
  - Cell's blink attribute is 1 and blink_phase is 1 → `bg_color`.
  - Cursor hit (`cursor_en`, col==cursor_col, row==cursor_row, glyph_row in {14,15}) and blink_phase is 0 → the cell's fg.
  - Glyph pixel is 1 → the cell's fg.
  - Otherwise → `bg_color`.

## Timing
- Pipeline of three `pix_tick`-qualified register stages:
  - Stage A registers coordinate-derived fields, `video_on`, the sync signals and the cursor hit.
  - Stage B is the buffer read, addressed from stage A.
  - Stage C is the output register. It combines stage B side data with font_word.
- Font ROM timing: `font_rom` has one clk of read latency. Its address comes from stage B and is held between ticks, so font_word is valid at the next tick.
- Latency: inputs sampled on tick n appear on `rgb_text`, `hsync_out` and `vsync_out` after the clk edge of tick n+2.
  - With `pix_tick` tied high this is 3 clks.
  - With a 1-in-4 tick it is 3 ticks.
- Reset values:
  - `rgb_text`=000, `hsync_out`=0, `vsync_out`=0.
  - `busy`=1, frame_cnt=0, blink_phase=0.
  - Buffer contents are defined only after the clear sweep completes.
- When `pix_tick` is 0, all pipeline registers hold their values. The clear FSM and the write port keep running.
- Reset mid-sweep restarts the sweep from address 0. The first `busy` falling edge after `reset_n` rises occurs COLS*ROWS clks later.

## Test plan
- Reset, S=1 (COLS=20, ROWS=15) → `busy`=1 for exactly 300 clks. Afterwards all visible pixels equal `bg_color`=3'b001 (space glyph).
- After the clear, write (0,0)={0,3'b100,7'h41} and scan row 0, y=2..3 → `rgb_text` matches font_rom 'A' row 1 bits, each bit spanning 2 pixels, with 100 on set bits and 001 on clear bits. Latency is 3 clks.
- Write with `wr_col`=20, or `wr_en` while `busy` → buffer unchanged. `video_on`=0 → `rgb_text`=000 regardless of contents.
- Blink cell with BLINK_FRAMES=2 and 4 frame starts → cell visible in frames 0-1 and shows `bg_color` in frames 2-3.
- `cursor_en` at (3,2) on a space → scaled glyph rows 14-15 (y=92..95, x=48..63) show FG_DEFAULT while blink_phase=0 and `bg_color` while blink_phase=1.
- `pix_tick` at 1-in-4 → output changes only 3 ticks after input. Sync outputs track `rgb_text` alignment. `clr` during a sweep does not extend `busy`.
